ama_riscv_csr_perf: RTL and testbench



---
 rtl/ama_riscv_csr_perf_if.sv | 20 ++
 rtl/ama_riscv_csr_perf.sv | 158 +++++++++++++++
 tb/tb_ama_riscv_csr_perf.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ama_riscv_csr_perf_if.sv
// CSR access bus between the EXE stage (master) and the counter CSR unit (slave).
interface ama_riscv_csr_perf_if;
   logic        csr_en;
   logic        csr_we;
   logic [11:0] csr_addr;
   logic [1:0]  csr_op;
   logic [31:0] csr_wdata;
   logic [31:0] csr_rdata;
   logic        csr_illegal;

   modport master (
      output csr_en, csr_we, csr_addr, csr_op, csr_wdata,
      input  csr_rdata, csr_illegal
   );

   modport slave (
      input  csr_en, csr_we, csr_addr, csr_op, csr_wdata,
      output csr_rdata, csr_illegal
   );
endinterface

// File: rtl/ama_riscv_csr_perf.sv
// Machine counter / performance-monitor CSR unit: mcycle, minstret, NUM_HPM
// programmable event counters, mcountinhibit and sticky wrap flags.
// Counter slot k follows the CSR numbering: 0 = cycle, 1 = unused (always 0),
// 2 = instret, 3+i = mhpmcounter(3+i).
module ama_riscv_csr_perf #(
   parameter int NUM_HPM    = 4,
   parameter int CNT_W      = 64,
   parameter int NUM_EVENTS = 8,
   parameter int EVT_W      = $clog2(NUM_EVENTS + 1)
) (
   input  logic                     clk,
   input  logic                     rst,
   ama_riscv_csr_perf_if.slave      csr,
   input  logic                     stall,
   input  logic                     inst_retire,
   input  logic [NUM_EVENTS-1:0]    events,
   output logic [NUM_HPM+2:0]       cnt_ovf
);

   localparam int NCNT = NUM_HPM + 3;
   localparam logic [NCNT-1:0] INH_MASK = ~(NCNT'(2));

   logic [CNT_W-1:0] cnt_q [NCNT];
   logic [CNT_W-1:0] cnt_d [NCNT];
   logic [EVT_W-1:0] evt_q [NCNT];
   logic [EVT_W-1:0] evt_d [NCNT];
   logic [NCNT-1:0]  inh_q, inh_d;
   logic [NCNT-1:0]  ovf_q, ovf_d;

   logic [NCNT-1:0]  hit_cnt;
   logic [NCNT-1:0]  hit_evt;
   logic             hit_inh;
   logic             addr_ok;
   logic             addr_hi;
   logic [31:0]      rdata;
   logic [31:0]      wval;
   logic             commit;

   // Address decode: which counter, selector or inhibit register is addressed
   always_comb begin
      hit_cnt = '0;
      hit_evt = '0;
      hit_inh = (csr.csr_addr == 12'h320);
      addr_hi = csr.csr_addr[7];
      for (int k = 0; k < NCNT; k++) begin
         if (k != 1) begin
            if ((csr.csr_addr == (12'hB00 + 12'(k))) ||
                (csr.csr_addr == (12'hB80 + 12'(k))))
               hit_cnt[k] = 1'b1;
         end
         if (k >= 3) begin
            if (csr.csr_addr == (12'h320 + 12'(k)))
               hit_evt[k] = 1'b1;
         end
      end
      addr_ok = (|hit_cnt) | (|hit_evt) | hit_inh;
   end

   // Combinational read mux; high halves are zero-extended above CNT_W
   always_comb begin
      logic [63:0] ext;
      rdata = '0;
      ext   = '0;
      if (csr.csr_en) begin
         for (int k = 0; k < NCNT; k++) begin
            if (hit_cnt[k]) begin
               ext   = 64'(cnt_q[k]);
               rdata = addr_hi ? ext[63:32] : ext[31:0];
            end
            if (hit_evt[k])
               rdata = 32'(evt_q[k]);
         end
         if (hit_inh)
            rdata = 32'(inh_q);
      end
   end

   assign csr.csr_rdata   = rdata;
   assign csr.csr_illegal = csr.csr_en & ~addr_ok;
   assign cnt_ovf         = ovf_q;

   // Read-modify-write value and the write-commit qualifier
   always_comb begin
      wval = csr.csr_wdata;
      case (csr.csr_op)
         2'b01:   wval = csr.csr_wdata;
         2'b10:   wval = rdata | csr.csr_wdata;
         2'b11:   wval = rdata & ~csr.csr_wdata;
         default: wval = rdata;
      endcase
      commit = csr.csr_en & csr.csr_we & (csr.csr_op != 2'b00) & ~stall & addr_ok;
   end

   // Next state: writes win over increments and clear the wrap flag
   always_comb begin
      logic             inc;
      logic [CNT_W:0]   sum;
      inh_d = inh_q;
      ovf_d = ovf_q;
      inc   = 1'b0;
      sum   = '0;
      for (int k = 0; k < NCNT; k++) begin
         cnt_d[k] = cnt_q[k];
         evt_d[k] = evt_q[k];
         inc      = 1'b0;
         if (k == 0) begin
            inc = 1'b1;
         end else if (k == 2) begin
            inc = inst_retire;
         end else if (k >= 3) begin
            for (int e = 0; e < NUM_EVENTS; e++) begin
               if (evt_q[k] == EVT_W'(e + 1))
                  inc = events[e];
            end
         end
         if (inh_q[k])
            inc = 1'b0;

         if (commit && hit_cnt[k]) begin
            if (addr_hi)
               cnt_d[k][CNT_W-1:32] = wval[CNT_W-33:0];
            else
               cnt_d[k][31:0] = wval;
            ovf_d[k] = 1'b0;
         end else if (inc) begin
            sum      = {1'b0, cnt_q[k]} + {{CNT_W{1'b0}}, 1'b1};
            cnt_d[k] = sum[CNT_W-1:0];
            if (sum[CNT_W])
               ovf_d[k] = 1'b1;
         end

         if (commit && hit_evt[k])
            evt_d[k] = (wval > 32'(NUM_EVENTS)) ? '0 : wval[EVT_W-1:0];
      end
      if (commit && hit_inh)
         inh_d = wval[NCNT-1:0] & INH_MASK;
   end

   // State registers with asynchronous active-low clear
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < NCNT; k++) begin
            cnt_q[k] <= '0;
            evt_q[k] <= '0;
         end
         inh_q <= '0;
         ovf_q <= '0;
      end else begin
         for (int k = 0; k < NCNT; k++) begin
            cnt_q[k] <= cnt_d[k];
            evt_q[k] <= evt_d[k];
         end
         inh_q <= inh_d;
         ovf_q <= ovf_d;
      end
   end

endmodule

// File: tb/tb_ama_riscv_csr_perf.sv
// Self-checking bench for ama_riscv_csr_perf with a 40-bit counter build.
module tb_ama_riscv_csr_perf;

   localparam int NUM_HPM    = 4;
   localparam int CNT_W      = 40;
   localparam int NUM_EVENTS = 8;
   localparam int NC         = NUM_HPM + 3;
   localparam logic [63:0] MASK = (64'd1 << CNT_W) - 64'd1;

   logic            clk = 1'b0;
   logic            rst;
   logic            stall;
   logic            inst_retire;
   logic [7:0]      events;
   logic [NC-1:0]   cnt_ovf;

   ama_riscv_csr_perf_if bus ();

   ama_riscv_csr_perf #(
      .NUM_HPM(NUM_HPM), .CNT_W(CNT_W), .NUM_EVENTS(NUM_EVENTS)
   ) dut (
      .clk(clk), .rst(rst), .csr(bus.slave), .stall(stall),
      .inst_retire(inst_retire), .events(events), .cnt_ovf(cnt_ovf)
   );

   always #25 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference state: counters as plain integers modulo 2^CNT_W
   logic [63:0]   m_cnt [NC];
   int            m_evt [NC];
   logic [NC-1:0] m_inh;
   logic [NC-1:0] m_ovf;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      for (int k = 0; k < NC; k++) begin
         m_cnt[k] = 64'd0;
         m_evt[k] = 0;
      end
      m_inh = '0;
      m_ovf = '0;
   endtask

   function automatic int cnt_idx(input logic [11:0] a);
      int i;
      if ((a >= 12'hB00 && a <= 12'hB1F) || (a >= 12'hB80 && a <= 12'hB9F)) begin
         i = int'(a & 12'h01F);
         if (i == 0 || (i >= 2 && i <= NUM_HPM + 2)) return i;
      end
      return -1;
   endfunction

   function automatic int evt_idx(input logic [11:0] a);
      if (a >= 12'h323 && a < 12'h323 + 12'(NUM_HPM)) return int'(a - 12'h320);
      return -1;
   endfunction

   function automatic bit m_legal(input logic [11:0] a);
      return (cnt_idx(a) >= 0) || (evt_idx(a) >= 0) || (a == 12'h320);
   endfunction

   function automatic logic [31:0] m_read(input logic [11:0] a, input logic en);
      int c;
      int e;
      logic [63:0] v;
      if (!en) return 32'd0;
      c = cnt_idx(a);
      e = evt_idx(a);
      if (c >= 0) begin
         v = m_cnt[c];
         return (a >= 12'hB80) ? v[63:32] : v[31:0];
      end
      if (e >= 0) return 32'(m_evt[e]);
      if (a == 12'h320) return 32'(m_inh);
      return 32'd0;
   endfunction

   // Advance the model by one clock using the inputs now on the bus, then
   // let the DUT take the same edge
   task automatic applyStimulus();
      logic [31:0] rd;
      logic [31:0] wv;
      bit          commit;
      bit          inc [NC];
      int          c;
      int          e;
      rd = m_read(bus.csr_addr, bus.csr_en);
      commit = bus.csr_en && bus.csr_we && (bus.csr_op != 2'b00) && !stall &&
               m_legal(bus.csr_addr);
      case (bus.csr_op)
         2'b10:   wv = rd | bus.csr_wdata;
         2'b11:   wv = rd & ~bus.csr_wdata;
         default: wv = bus.csr_wdata;
      endcase
      for (int k = 0; k < NC; k++) begin
         inc[k] = !m_inh[k] && ((k == 0) || (k == 2 && inst_retire === 1'b1) ||
                  (k >= 3 && m_evt[k] >= 1 && m_evt[k] <= NUM_EVENTS &&
                   events[m_evt[k] - 1] === 1'b1));
      end
      c = cnt_idx(bus.csr_addr);
      e = evt_idx(bus.csr_addr);
      for (int k = 0; k < NC; k++) begin
         if (commit && c == k) begin
            if (bus.csr_addr >= 12'hB80)
               m_cnt[k] = (({32'd0, wv} << 32) | (m_cnt[k] & 64'hFFFF_FFFF)) & MASK;
            else
               m_cnt[k] = (m_cnt[k] & ~64'hFFFF_FFFF) | {32'd0, wv};
            m_ovf[k] = 1'b0;
         end else if (inc[k]) begin
            if (m_cnt[k] == MASK) begin
               m_cnt[k] = 64'd0;
               m_ovf[k] = 1'b1;
            end else begin
               m_cnt[k] = m_cnt[k] + 64'd1;
            end
         end
      end
      if (commit && e >= 0)
         m_evt[e] = (wv > 32'(NUM_EVENTS)) ? 0 : int'(wv);
      if (commit && bus.csr_addr == 12'h320)
         m_inh = wv[NC-1:0] & 7'b1111101;
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
      bus.csr_en    = 1'b1;
      bus.csr_we    = 1'b1;
      bus.csr_addr  = a;
      bus.csr_op    = op;
      bus.csr_wdata = d;
      applyStimulus();
      bus.csr_we    = 1'b0;
      bus.csr_op    = 2'b00;
   endtask

   // Read an address and compare data and illegal flag against the model
   task automatic checkOutput(input string tag, input logic [11:0] a);
      bus.csr_en   = 1'b1;
      bus.csr_we   = 1'b0;
      bus.csr_addr = a;
      #1;
      chk(tag, bus.csr_rdata, m_read(a, 1'b1));
      chk({tag, "_ill"}, bus.csr_illegal, !m_legal(a));
   endtask

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [11:0] pool [20];
      logic [63:0] prev;
      pool = '{12'hB00, 12'hB02, 12'hB03, 12'hB04, 12'hB05, 12'hB06, 12'hB80,
               12'hB82, 12'hB83, 12'hB86, 12'h320, 12'h323, 12'h324, 12'h326,
               12'hB01, 12'hB1F, 12'h327, 12'hB87, 12'h000, 12'hB07};
      m_reset();
      rst = 1'b0;
      stall = 1'b0;
      inst_retire = 1'b0;
      events = '0;
      bus.csr_en = 1'b0;
      bus.csr_we = 1'b0;
      bus.csr_addr = '0;
      bus.csr_op = 2'b00;
      bus.csr_wdata = '0;
      repeat (2) @(posedge clk);
      #1;

      // Reset state, then ten cycles of retirement
      bus.csr_en = 1'b1;
      bus.csr_addr = 12'hB00;
      #1;
      chk("rst_cy", bus.csr_rdata, 64'd0);
      chk("rst_ovf", cnt_ovf, 64'd0);
      bus.csr_en = 1'b0;
      rst = 1'b1;
      inst_retire = 1'b1;
      repeat (10) applyStimulus();
      checkOutput("cy10", 12'hB00);
      chk("cy10_const", bus.csr_rdata, 64'd10);
      checkOutput("ir10", 12'hB02);
      chk("ir10_const", bus.csr_rdata, 64'd10);
      chk("ovf_clean", cnt_ovf, {57'd0, m_ovf});
      inst_retire = 1'b0;

      // High-half write leaves the low half alone and blocks the increment
      wr(12'hB00, 2'b01, 32'd5);
      checkOutput("cy5", 12'hB00);
      wr(12'hB80, 2'b01, 32'h1234_5678);
      checkOutput("cyh", 12'hB80);
      chk("cyh_const", bus.csr_rdata, 64'h78);
      checkOutput("cy_hold", 12'hB00);
      chk("cy_hold_const", bus.csr_rdata, 64'd5);
      applyStimulus();
      checkOutput("cy6", 12'hB00);
      chk("cy6_const", bus.csr_rdata, 64'd6);

      // Event selection
      wr(12'h323, 2'b01, 32'd3);
      wr(12'hB03, 2'b01, 32'd0);
      events = 8'h04;
      repeat (7) applyStimulus();
      events = 8'h01;
      repeat (4) applyStimulus();
      events = 8'h00;
      checkOutput("hpm3", 12'hB03);
      chk("hpm3_const", bus.csr_rdata, 64'd7);
      wr(12'h323, 2'b01, 32'(NUM_EVENTS + 1));
      checkOutput("sel_warl", 12'h323);
      chk("sel_warl_const", bus.csr_rdata, 64'd0);
      events = 8'hFF;
      repeat (5) applyStimulus();
      events = 8'h00;
      checkOutput("hpm3_stop", 12'hB03);
      chk("hpm3_stop_const", bus.csr_rdata, 64'd7);

      // Wrap and sticky overflow
      wr(12'hB80, 2'b01, 32'hFF);
      wr(12'hB00, 2'b01, 32'hFFFF_FFFE);
      applyStimulus();
      chk("ovf_pre", cnt_ovf[0], 64'd0);
      applyStimulus();
      chk("ovf_set", cnt_ovf[0], 64'd1);
      checkOutput("wrap_lo", 12'hB00);
      chk("wrap_lo_const", bus.csr_rdata, 64'd0);
      checkOutput("wrap_hi", 12'hB80);
      chk("wrap_hi_const", bus.csr_rdata, 64'd0);
      applyStimulus();
      chk("ovf_sticky", cnt_ovf[0], 64'd1);
      wr(12'hB00, 2'b01, 32'd0);
      chk("ovf_clr", cnt_ovf[0], 64'd0);
      chk("ovf_all", cnt_ovf, {57'd0, m_ovf});

      // Inhibit minstret
      wr(12'h320, 2'b10, 32'd4);
      checkOutput("inh", 12'h320);
      chk("inh_const", bus.csr_rdata, 64'd4);
      inst_retire = 1'b1;
      repeat (3) applyStimulus();
      inst_retire = 1'b0;
      checkOutput("ir_inh", 12'hB02);
      chk("ir_inh_const", bus.csr_rdata, 64'd10);
      wr(12'h320, 2'b01, 32'hFFFF_FFFF);
      checkOutput("inh_warl", 12'h320);
      chk("inh_warl_const", bus.csr_rdata, 64'h7D);
      wr(12'h320, 2'b01, 32'd0);

      // Stalled write does not commit; cycles keep counting
      prev = m_cnt[0];
      stall = 1'b1;
      wr(12'hB03, 2'b01, 32'hABCD);
      stall = 1'b0;
      checkOutput("stall_hpm", 12'hB03);
      chk("stall_hpm_const", bus.csr_rdata, 64'd7);
      checkOutput("stall_cy", 12'hB00);
      chk("stall_cy_adv", bus.csr_rdata, (prev + 64'd1) & 64'hFFFF_FFFF);

      // Illegal addresses
      bus.csr_en = 1'b1;
      bus.csr_addr = 12'hB1F;
      #1;
      chk("ill_flag", bus.csr_illegal, 64'd1);
      chk("ill_data", bus.csr_rdata, 64'd0);
      wr(12'hB1F, 2'b01, 32'hFFFF);
      for (int k = 0; k < NC; k++) begin
         if (k != 1) checkOutput($sformatf("ill_cnt%0d", k), 12'hB00 + 12'(k));
      end
      checkOutput("ill_b01", 12'hB01);
      checkOutput("ill_327", 12'h327);
      checkOutput("ill_b87", 12'hB87);
      checkOutput("leg_b86", 12'hB86);
      bus.csr_en = 1'b0;
      #1;
      chk("ill_noen", bus.csr_illegal, 64'd0);
      chk("rd_noen", bus.csr_rdata, 64'd0);

      // Randomised traffic against the model
      for (int n = 0; n < 400; n++) begin
         bus.csr_en   = ($urandom_range(0, 3) != 0);
         bus.csr_we   = $urandom_range(0, 1);
         bus.csr_addr = pool[$urandom_range(0, 19)];
         bus.csr_op   = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 4))
            0: bus.csr_wdata = 32'hFFFF_FFFF;
            1: bus.csr_wdata = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            2: bus.csr_wdata = 32'($urandom_range(0, 12));
            default: bus.csr_wdata = $urandom;
         endcase
         stall       = ($urandom_range(0, 3) == 0);
         inst_retire = $urandom_range(0, 1);
         events      = 8'($urandom);
         #1;
         chk("rnd_rdata", bus.csr_rdata, m_read(bus.csr_addr, bus.csr_en));
         chk("rnd_ill", bus.csr_illegal, bus.csr_en && !m_legal(bus.csr_addr));
         applyStimulus();
         chk("rnd_ovf", cnt_ovf, {57'd0, m_ovf});
      end
      stall = 1'b0;
      inst_retire = 1'b0;
      events = '0;
      bus.csr_we = 1'b0;
      for (int k = 0; k < NC; k++) begin
         if (k != 1) checkOutput($sformatf("rnd_lo%0d", k), 12'hB00 + 12'(k));
         if (k != 1) checkOutput($sformatf("rnd_hi%0d", k), 12'hB80 + 12'(k));
      end

      // Reset in the middle of a pending write
      wr(12'h320, 2'b01, 32'd0);
      bus.csr_en = 1'b1;
      bus.csr_we = 1'b1;
      bus.csr_addr = 12'hB00;
      bus.csr_op = 2'b01;
      bus.csr_wdata = 32'h55;
      #1;
      rst = 1'b0;
      m_reset();
      #1;
      chk("mid_rst_ovf", cnt_ovf, 64'd0);
      checkOutput("mid_rst_cy", 12'hB00);
      checkOutput("mid_rst_evt", 12'h323);
      @(posedge clk);
      #1;
      rst = 1'b1;
      bus.csr_we = 1'b0;
      bus.csr_op = 2'b00;
      repeat (2) applyStimulus();
      checkOutput("post_rst_cy", 12'hB00);
      chk("post_rst_cy_const", bus.csr_rdata, 64'd2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
